// File: rtl/cache_req_sequencer_if.sv
// Request/response and cache-array bus bundle for cache_req_sequencer.
// The master side is the sequencer; the slave side is the request source and array.
interface cache_req_sequencer_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int WORD_WIDTH = 32,
   parameter int BVAL_WIDTH = 4
);
   logic [ADDR_WIDTH-1:0] cache_sys_addr;
   logic [WORD_WIDTH-1:0] cache_sys_wdata;
   logic [BVAL_WIDTH-1:0] cache_sys_bval;
   logic                  cache_sys_rd;
   logic                  cache_sys_wr;
   logic [WORD_WIDTH-1:0] cache_sys_rdata;
   logic                  cache_sys_ack;
   logic                  tx_fifo_ctrl;
   logic                  mem_req;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [WORD_WIDTH-1:0] mem_wdata;
   logic [BVAL_WIDTH-1:0] mem_bval;
   logic                  mem_gnt;
   logic                  mem_rvalid;
   logic [WORD_WIDTH-1:0] mem_rdata;
   logic                  overflow;
   logic                  proto_err;
   logic                  busy;

   modport master (
      input  cache_sys_addr, cache_sys_wdata, cache_sys_bval, cache_sys_rd, cache_sys_wr,
      input  mem_gnt, mem_rvalid, mem_rdata,
      output cache_sys_rdata, cache_sys_ack, tx_fifo_ctrl,
      output mem_req, mem_we, mem_addr, mem_wdata, mem_bval,
      output overflow, proto_err, busy
   );

   modport slave (
      output cache_sys_addr, cache_sys_wdata, cache_sys_bval, cache_sys_rd, cache_sys_wr,
      output mem_gnt, mem_rvalid, mem_rdata,
      input  cache_sys_rdata, cache_sys_ack, tx_fifo_ctrl,
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_bval,
      input  overflow, proto_err, busy
   );
endinterface

// File: rtl/cache_req_sequencer.sv
// Queues single-cycle cache requests and issues them in order, one at a time,
// to the cache array over req/gnt/rvalid, returning one ack per request.
module cache_req_sequencer #(
   parameter int ADDR_WIDTH = 16,
   parameter int WORD_WIDTH = 32,
   parameter int BVAL_WIDTH = 4,
   parameter int QDEPTH     = 4
) (
   input logic                    cache_clk,
   input logic                    rst,
   cache_req_sequencer_if.master  bus
);
   localparam int PTR_W = $clog2(QDEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_R, S_RESP} state_t;

   state_t                state_q, state_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
   logic [BVAL_WIDTH-1:0] bval_q, bval_d;
   logic [WORD_WIDTH-1:0] rdata_q, rdata_d;
   logic                  overflow_q, overflow_d;
   logic                  proto_err_q, proto_err_d;

   // Queue storage holds no control state, so it is left out of reset.
   logic                  fifo_rd_q    [QDEPTH];
   logic [ADDR_WIDTH-1:0] fifo_addr_q  [QDEPTH];
   logic [WORD_WIDTH-1:0] fifo_wdata_q [QDEPTH];
   logic [BVAL_WIDTH-1:0] fifo_bval_q  [QDEPTH];

   logic push_req, full, push_ok, pop;

   assign push_req = bus.cache_sys_rd ^ bus.cache_sys_wr;
   assign full     = (count_q == CNT_W'(QDEPTH));
   // A full queue still accepts a push when the head leaves in the same cycle.
   assign push_ok  = push_req && (!full || pop);

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      bval_d  = bval_q;
      rdata_d = rdata_q;
      pop     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (count_q != '0) begin
               pop     = 1'b1;
               state_d = S_ISSUE;
               we_d    = ~fifo_rd_q[rd_ptr_q];
               addr_d  = fifo_addr_q[rd_ptr_q];
               wdata_d = fifo_wdata_q[rd_ptr_q];
               bval_d  = fifo_bval_q[rd_ptr_q];
            end
         end
         S_ISSUE: begin
            if (bus.mem_gnt) begin
               if (we_q) begin
                  state_d = S_RESP;
                  rdata_d = '0;
               end else begin
                  state_d = S_WAIT_R;
               end
            end
         end
         S_WAIT_R: begin
            if (bus.mem_rvalid) begin
               rdata_d = bus.mem_rdata;
               state_d = S_RESP;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_d    = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d    = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d     = count_q;
      if (push_ok && !pop) count_d = count_q + CNT_W'(1);
      if (!push_ok && pop) count_d = count_q - CNT_W'(1);
      overflow_d  = overflow_q | (push_req & full & ~pop);
      proto_err_d = proto_err_q | (bus.cache_sys_rd & bus.cache_sys_wr);
   end

   always_ff @(posedge cache_clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         bval_q      <= '0;
         rdata_q     <= '0;
         overflow_q  <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         bval_q      <= bval_d;
         rdata_q     <= rdata_d;
         overflow_q  <= overflow_d;
         proto_err_q <= proto_err_d;
      end
   end

   always_ff @(posedge cache_clk) begin
      if (push_ok) begin
         fifo_rd_q[wr_ptr_q]    <= bus.cache_sys_rd;
         fifo_addr_q[wr_ptr_q]  <= bus.cache_sys_addr;
         fifo_wdata_q[wr_ptr_q] <= bus.cache_sys_wdata;
         fifo_bval_q[wr_ptr_q]  <= bus.cache_sys_bval;
      end
   end

   assign bus.mem_req         = (state_q == S_ISSUE);
   assign bus.mem_we          = we_q;
   assign bus.mem_addr        = addr_q;
   assign bus.mem_wdata       = wdata_q;
   assign bus.mem_bval        = bval_q;
   assign bus.cache_sys_ack   = (state_q == S_RESP);
   assign bus.tx_fifo_ctrl    = (state_q == S_RESP);
   assign bus.cache_sys_rdata = rdata_q;
   assign bus.overflow        = overflow_q;
   assign bus.proto_err       = proto_err_q;
   assign bus.busy            = (count_q != '0) || (state_q != S_IDLE);
endmodule

// File: doc/cache_req_sequencer.md
Name: cache_req_sequencer

Overview:
- Cache-clock-domain stage directly downstream of the CPU-to-cache clock-crossing interface.
- Consumes its single-cycle cache_sys_rd/cache_sys_wr request pulses; the interface applies no backpressure, so requests go into a local request queue.
- Issues queued requests one at a time to the cache array port with a req/gnt/rvalid handshake.
- Returns cache_sys_ack/cache_sys_rdata, plus the RX-FIFO write strobe tx_fifo_ctrl that carries the response back to the CPU domain.

Parameters:
ADDR_WIDTH, 16, request address width
WORD_WIDTH, 32, data word width
BVAL_WIDTH, 4, byte-valid mask width
QDEPTH, 4, request queue depth in entries; power of two, minimum 2

Ports:
cache_clk  in  1  sole clock; all logic on the rising edge
rst  in  1  asynchronous, active-low reset
cache_sys_addr  in  ADDR_WIDTH  request address
cache_sys_wdata  in  WORD_WIDTH  write data
cache_sys_bval  in  BVAL_WIDTH  byte-valid mask
cache_sys_rd  in  1  read request pulse, one cycle per request
cache_sys_wr  in  1  write request pulse, one cycle per request
cache_sys_rdata  out  WORD_WIDTH  response data
cache_sys_ack  out  1  response strobe, one cycle per completed request
tx_fifo_ctrl  out  1  RX FIFO write enable; identical to cache_sys_ack
mem_req  out  1  array request valid
mem_we  out  1  1 = write, 0 = read; valid while mem_req=1
mem_addr  out  ADDR_WIDTH  array address
mem_wdata  out  WORD_WIDTH  array write data
mem_bval  out  BVAL_WIDTH  array byte enables
mem_gnt  in  1  array accepts the request this cycle
mem_rvalid  in  1  read data valid
mem_rdata  in  WORD_WIDTH  read data
overflow  out  1  sticky: a request was dropped because the queue was full
proto_err  out  1  sticky: rd and wr were sampled high together
busy  out  1  queue non-empty or FSM not IDLE

Behaviour:
- Reset (rst=0, asynchronous)
  - All outputs 0, queue empty, FSM in IDLE, sticky flags cleared.
  - Reset mid-transaction drops mem_req immediately and discards the in-flight request and all queued requests.
  - A mem_rvalid arriving after reset release while the FSM is IDLE is ignored.
- Queue push
  - rd XOR wr sampled high pushes {op, addr, wdata, bval}; op=1 means read.
  - rd=wr=1 pushes nothing and sets proto_err.
  - Push while full with no pop in the same cycle: request dropped, overflow set, queue unchanged.
  - Push while full and a pop occurs in the same cycle: push accepted.
  - Pointers wrap modulo QDEPTH. Count is log2(QDEPTH)+1 bits.
- Pop: occurs only on the IDLE->ISSUE transition. The head entry is loaded into the issue registers that drive mem_*.
- FSM states
  - IDLE: queue non-empty -> ISSUE (pop).
  - ISSUE
    - mem_req=1; mem_we/addr/wdata/bval held stable until mem_gnt=1 is sampled.
    - On gnt: write -> RESP; read -> WAIT_R.
    - For writes, mem_gnt is the completion (posted write).
  - WAIT_R
    - mem_req=0. Waits indefinitely for mem_rvalid.
    - On mem_rvalid: capture mem_rdata into the response register -> RESP.
  - RESP
    - cache_sys_ack=tx_fifo_ctrl=1 for exactly one cycle -> IDLE.
    - cache_sys_rdata = captured read data for reads; 0 for writes.
  - cache_sys_rdata holds its value after the ack cycle until the next RESP.
  - mem_rvalid outside WAIT_R is ignored.
- Latency (request sampled at edge E0)
  - mem_req rises after E1.
  - Write with gnt sampled at E2: ack high in cycle E2–E3.
  - Read with gnt at E2 and rvalid at E3: ack high in cycle E3–E4.
  - Back-to-back: the next mem_req rises one cycle after the ack cycle, because RESP returns to IDLE before the next pop.
- Ordering: strictly in order; one outstanding array request at a time.
- busy: combinational OR of (count≠0) and (state≠IDLE).

Test Plan:
- Single write addr=0x0010, wdata=0xDEADBEEF, bval=0xF, mem_gnt tied 1 -> mem_req/mem_we=1 with those values in one cycle; ack=tx_fifo_ctrl=1 two cycles after the request, rdata=0.
- Single read addr=0x0020, gnt after 3 wait cycles, rvalid 2 cycles later with 0xCAFEF00D -> mem_* held stable through the wait; one ack cycle with rdata=0xCAFEF00D; ack never repeats.
- Six consecutive request pulses, QDEPTH=4, mem_gnt held 0 -> first entry popped into ISSUE, next 4 queued, 6th dropped, overflow=1. Release gnt -> exactly 5 acks in submission order.
- Same-cycle rd=wr=1 -> no push, proto_err=1, no mem_req. A following legal read completes normally.
- Push on a full queue in the same cycle as an IDLE->ISSUE pop -> push accepted, overflow stays 0, count stays QDEPTH.
- rst asserted during WAIT_R with 2 entries queued -> mem_req, ack and busy go 0 immediately. After release, a late mem_rvalid produces no ack; a new request completes normally.
